cordic_serial_axis: RTL

//   Parametrised bit-serial CORDIC axis register: holds one W-bit two's-complement coordinate,

---
 rtl/cordic_serial_axis_if.sv | 34 +++
 rtl/cordic_serial_axis.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/cordic_serial_axis_if.sv
// ----------------------------------------------------------------------------
// cordic_serial_axis_if
//   Bundles the control, serial-operand and result signals of one bit-serial
//   CORDIC axis register.
//   master : iteration controller side (drives load/init/start/op/operand_bit/sel,
//            observes tap_bit/busy/done/ovf/value)
//   slave  : axis register side (the reverse directions)
// ----------------------------------------------------------------------------
interface cordic_serial_axis_if #(
  parameter int W     = 16,
  parameter int SEL_W = $clog2(W)
);
  logic             load;
  logic [W-1:0]     init;
  logic             start;
  logic             op;
  logic             operand_bit;
  logic [SEL_W-1:0] sel;
  logic             tap_bit;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [W-1:0]     value;

  modport master (
    output load, init, start, op, operand_bit, sel,
    input  tap_bit, busy, done, ovf, value
  );

  modport slave (
    input  load, init, start, op, operand_bit, sel,
    output tap_bit, busy, done, ovf, value
  );
endinterface

// File: rtl/cordic_serial_axis.sv
// ----------------------------------------------------------------------------
// cordic_serial_axis
//   Bit-serial CORDIC axis register. Holds one W-bit two's-complement
//   coordinate and adds or subtracts a serial operand (LSB first) over W
//   cycles through a single full adder. Feeds the partner axis an
//   arithmetically shifted (value >>> sel) tap bit, one bit per cycle.
// Ports
//   clk    : clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : cordic_serial_axis_if.slave (load/init/start/op/operand_bit/sel in,
//            tap_bit/busy/done/ovf/value out)
// Configuration
//   CORDIC_SAT_EN : when defined, an overflowing pass leaves the saturation
//                   bound in value instead of the wrapped result.
// ----------------------------------------------------------------------------
module cordic_serial_axis #(
  parameter int W     = 16,
  parameter int SEL_W = $clog2(W),
  parameter int CNT_W = $clog2(W) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cordic_serial_axis_if.slave  bus
);

  localparam int SUM_W = CNT_W + SEL_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     value_q, value_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             op_q,    op_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic             sign_q,  sign_d;
  logic             ovf_q,   ovf_d;

  logic             b_s;
  logic             sum_s;
  logic             cout_s;
  logic             tap_s;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Serial full adder on the current LSB; subtraction inverts the operand bit
  // and seeds carry with 1 at start.
  always_comb begin
    b_s    = bus.operand_bit ^ op_q;
    sum_s  = value_q[0] ^ b_s ^ carry_q;
    cout_s = maj3(value_q[0], b_s, carry_q);
  end

  // Next-state logic for the pass sequencer and datapath registers.
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sel_d   = sel_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          value_d = bus.init;
        end else if (bus.start) begin
          op_d    = bus.op;
          sel_d   = bus.sel;
          sign_d  = value_q[W-1];
          carry_d = bus.op;
          cnt_d   = {CNT_W{1'b0}};
          ovf_d   = 1'b0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        carry_d = cout_s;
        value_d = {sum_s, value_q[W-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W - 1)) begin
          // Overflow when carry into the MSB differs from carry out of it.
          ovf_d   = carry_q ^ cout_s;
          state_d = ST_DONE;
`ifdef CORDIC_SAT_EN
          // Wrapped MSB set means positive overflow, clear means negative.
          if (carry_q ^ cout_s) begin
            value_d = sum_s ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
          end else begin
            value_d = {sum_s, value_q[W-1:1]};
          end
`else
        end else begin
          state_d = ST_SHIFT;
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Tap bit: the register rotates right during a pass, so position sel_q holds
  // original bit k+sel_q until that index runs past the MSB, then sign fills.
  always_comb begin
    tap_s = value_q[W-1];
    if (state_q == ST_SHIFT) begin
      if ((SUM_W'(cnt_q) + SUM_W'(sel_q)) <= SUM_W'(W - 1)) begin
        tap_s = value_q[sel_q];
      end else begin
        tap_s = sign_q;
      end
    end else begin
      if (SUM_W'(bus.sel) <= SUM_W'(W - 1)) begin
        tap_s = value_q[bus.sel];
      end else begin
        tap_s = value_q[W-1];
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      value_q <= {W{1'b0}};
      carry_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      op_q    <= 1'b0;
      sel_q   <= {SEL_W{1'b0}};
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy    = (state_q == ST_SHIFT);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.ovf     = ovf_q;
  assign bus.value   = value_q;
  assign bus.tap_bit = tap_s;

endmodule
